// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared types and constants for the CPU data-memory path.
//   arb_state_t : data-memory arbiter FSM states
//   REQ_CU/LD   : requester indices (control unit, program/data loader)
//   DMEM_*_W    : default data-memory address / data widths
// -----------------------------------------------------------------------------
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } arb_state_t;

    localparam int REQ_CU      = 0;
    localparam int REQ_LD      = 1;
    localparam int DMEM_ADDR_W = 8;
    localparam int DMEM_DATA_W = 16;

endpackage

// File: rtl/dmem_rr_pick.sv
// -----------------------------------------------------------------------------
// dmem_rr_pick
// Combinational two-way round-robin winner select.
//   req_i   : per-requester request bits
//   ptr_i   : index of the requester that wins a tie
//   win_o   : winning requester index (meaningful only with valid_o)
//   valid_o : at least one request is pending
// -----------------------------------------------------------------------------
module dmem_rr_pick (
    input  logic [1:0] req_i,
    input  logic       ptr_i,
    output logic       win_o,
    output logic       valid_o
);

    always_comb begin
        valid_o = |req_i;
        // A lone request wins outright; a tie goes to the pointer.
        if (req_i == 2'b11) begin
            win_o = ptr_i;
        end else begin
            win_o = req_i[1];
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares a single-port data memory between the control unit (port 0) and the
// program/data loader (port 1). One transaction in flight, round-robin on
// ties, fixed memory read latency absorbed internally. All outputs registered.
//   clk_i, rst_i        : clock, synchronous active-high reset
//   req_i, wr_i         : per-port request / write-enable
//   addr0_i, addr1_i    : per-port address
//   wdata0_i, wdata1_i  : per-port write data
//   gnt_o, ack_o        : one-hot single-cycle accept / complete pulses
//   rdata_o             : read return, valid with ack_o on a read
//   d_addr_o, d_wr_o, d_wdata_o, d_rdata_i : memory side
// -----------------------------------------------------------------------------
module dmem_arbiter
    import cpu_pkg::*;
#(
    parameter int ADDR_W = DMEM_ADDR_W,
    parameter int DATA_W = DMEM_DATA_W,
    parameter int RD_LAT = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [1:0]        req_i,
    input  logic [1:0]        wr_i,
    input  logic [ADDR_W-1:0] addr0_i,
    input  logic [ADDR_W-1:0] addr1_i,
    input  logic [DATA_W-1:0] wdata0_i,
    input  logic [DATA_W-1:0] wdata1_i,
    output logic [1:0]        gnt_o,
    output logic [1:0]        ack_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic [ADDR_W-1:0] d_addr_o,
    output logic              d_wr_o,
    output logic [DATA_W-1:0] d_wdata_o,
    input  logic [DATA_W-1:0] d_rdata_i
);

    generate
        if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_lat
            $error("dmem_arbiter: RD_LAT must be in 1..4");
        end
    endgenerate

    localparam int CNT_W = 2;

    arb_state_t        state_q, state_d;
    logic [1:0]        gnt_q, gnt_d;
    logic [1:0]        ack_q, ack_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [ADDR_W-1:0] d_addr_q, d_addr_d;
    logic              d_wr_q, d_wr_d;
    logic [DATA_W-1:0] d_wdata_q, d_wdata_d;
    logic              ptr_q, ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              win_q, win_d;
    logic              wr_q, wr_d;

    logic pick_win;
    logic pick_valid;

    dmem_rr_pick u_pick (
        .req_i   (req_i),
        .ptr_i   (ptr_q),
        .win_o   (pick_win),
        .valid_o (pick_valid)
    );

    // State and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            ack_q     <= '0;
            rdata_q   <= '0;
            d_addr_q  <= '0;
            d_wr_q    <= 1'b0;
            d_wdata_q <= '0;
            ptr_q     <= 1'b0;
            cnt_q     <= '0;
            win_q     <= 1'b0;
            wr_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            ack_q     <= ack_d;
            rdata_q   <= rdata_d;
            d_addr_q  <= d_addr_d;
            d_wr_q    <= d_wr_d;
            d_wdata_q <= d_wdata_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            win_q     <= win_d;
            wr_q      <= wr_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_valid) state_d = ACCESS;
            ACCESS:  state_d = (wr_q || RD_LAT == 1) ? RESP : WAIT;
            WAIT:    if (cnt_q == CNT_W'(1)) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs and datapath.
    always_comb begin
        gnt_d     = '0;
        ack_d     = '0;
        rdata_d   = rdata_q;
        d_addr_d  = d_addr_q;
        d_wr_d    = d_wr_q;
        d_wdata_d = d_wdata_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        win_d     = win_q;
        wr_d      = wr_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    win_d           = pick_win;
                    wr_d            = wr_i[pick_win];
                    gnt_d[pick_win] = 1'b1;
                    d_addr_d        = pick_win ? addr1_i : addr0_i;
                    d_wr_d          = wr_i[pick_win];
                    d_wdata_d       = pick_win ? wdata1_i : wdata0_i;
                end else begin
                    d_addr_d  = '0;
                    d_wr_d    = 1'b0;
                    d_wdata_d = '0;
                end
            end
            ACCESS: begin
                // Exactly one cycle of write enable.
                d_wr_d = 1'b0;
                if (wr_q) begin
                    ack_d[win_q] = 1'b1;
                end else begin
                    cnt_d = CNT_W'(RD_LAT - 1);
                    if (RD_LAT == 1) begin
                        rdata_d      = d_rdata_i;
                        ack_d[win_q] = 1'b1;
                    end
                end
            end
            WAIT: begin
                // Address held; capture when the count would reach zero.
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    rdata_d      = d_rdata_i;
                    ack_d[win_q] = 1'b1;
                end
            end
            RESP: begin
                d_addr_d = '0;
                // Hand tie priority to the requester not just served.
                ptr_d    = ~win_q;
            end
            default: ;
        endcase
    end

    assign gnt_o     = gnt_q;
    assign ack_o     = ack_q;
    assign rdata_o   = rdata_q;
    assign d_addr_o  = d_addr_q;
    assign d_wr_o    = d_wr_q;
    assign d_wdata_o = d_wdata_q;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single-port data memory between two requesters: port 0 is the control unit (LOAD/STORE) and port 1 is the program/data loader (boot image, debug peek/poke). It uses round-robin arbitration with a req/gnt/ack handshake. Exactly one transaction is in flight at a time. It absorbs the memory's fixed read latency, so neither requester drives the memory's D_ADDR/D_WR directly.

Parameters:
ADDR_W, 8, data memory address width
DATA_W, 16, data word width
RD_LAT, 1, memory read latency in cycles from address valid to D_RDATA valid; legal range 1..4, elaboration error otherwise

Ports:
Clock  in  1  system clock, all state updates on posedge
Reset  in  1  synchronous, active-high
REQ  in  2  per-requester request; held high with fields stable until that requester's ACK
WR  in  2  per-requester 1=write, 0=read
ADDR0, ADDR1  in  ADDR_W each  per-requester address
WDATA0, WDATA1  in  DATA_W each  per-requester write data
GNT  out  2  one-hot one-cycle pulse: transaction accepted
ACK  out  2  one-hot one-cycle pulse: transaction complete; RDATA valid this cycle for reads
RDATA  out  DATA_W  shared read-return bus, valid only with an ACK bit on a read
D_ADDR  out  ADDR_W  memory address
D_WR  out  1  memory write enable
D_WDATA  out  DATA_W  memory write data
D_RDATA  in  DATA_W  memory read data

Behaviour:
- All outputs are registered. Reset (any state, including mid-transaction) forces: state=IDLE, GNT=0, ACK=0, RDATA=0, D_ADDR=0, D_WR=0, D_WDATA=0, priority pointer=0, latency counter=0. An aborted transaction gets no ACK. D_WR is low the cycle after the Reset edge.
- FSM states: IDLE, ACCESS, WAIT, RESP.
- IDLE, at edge N:
  - if any REQ bit is high: pick the winner, latch its WR/ADDR/WDATA, GNT[w]<=1, D_ADDR<=addr, D_WR<=wr, D_WDATA<=wdata, go to ACCESS.
  - else: D_ADDR/D_WR/D_WDATA are 0.
- Arbitration:
  - only one REQ high: that requester wins.
  - both high: the requester named by the priority pointer wins.
  - pointer <= ~winner at the RESP exit, so the requester not just served has priority.
- ACCESS, one cycle, GNT deasserts:
  - write: D_WR<=0, ACK[w]<=1, go to RESP. Write ACK is at edge N+2, with exactly one D_WR cycle.
  - read: counter<=RD_LAT-1. If RD_LAT==1, capture RDATA<=D_RDATA, ACK[w]<=1, go to RESP. Otherwise go to WAIT.
- WAIT: D_ADDR held. Decrement the counter; when it reaches 0, capture RDATA<=D_RDATA, ACK[w]<=1, go to RESP.
  - Read ACK is at edge N+1+RD_LAT.
- RESP, one cycle:
  - ACK[w] high; RDATA holds its value until the next read capture.
  - D_ADDR<=0; update the pointer; go to IDLE.
  - IDLE re-samples REQ at edge N+3 at the earliest (write or RD_LAT=1). A requester that drops REQ on the edge after ACK is therefore never double-granted.
- While not in IDLE, new REQ bits are ignored; the losing requester keeps REQ high and waits.
- A requester dropping REQ after GNT does not abort the transaction. Its ACK still pulses.
- GNT and ACK are each at most one-hot and never asserted simultaneously.
- Back-to-back throughput: one transaction per 3 cycles (write or RD_LAT=1), or 2+RD_LAT cycles for reads in general.

Decomposition:
- Shared package cpu_pkg:
  - arb_state_t enum {IDLE, ACCESS, WAIT, RESP}
  - constants REQ_CU=0 and REQ_LD=1
  - DMEM_ADDR_W=8, DMEM_DATA_W=16
- One natural sub-module, dmem_rr_pick: combinational winner select from REQ[1:0] and pointer, output a winner index plus a valid flag.
- The latency counter and FSM stay in dmem_arbiter.

Test Plan:
- Reset high 2 cycles, then low with REQ=0 -> all outputs 0, no GNT/ACK for 10 cycles.
- REQ=01, WR0=1, ADDR0=0x3C, WDATA0=0xBEEF, sampled at edge N -> GNT=01 and D_WR=1, D_ADDR=0x3C, D_WDATA=0xBEEF in cycle N+1; ACK=01 at N+2; memory[0x3C]=0xBEEF.
- RD_LAT=3, REQ=10, WR1=0, ADDR1=0x3C -> GNT=10 at N+1, ACK=10 at N+4 with RDATA=0xBEEF; D_ADDR held 0x3C from N+1 to N+4.
- REQ=11 held continuously, pointer=0 after reset -> grant order 01,10,01,10; each ACK matches its GNT; no port starved.
- Reset asserted during WAIT of a read -> no ACK, D_ADDR=0 and state=IDLE next cycle; pointer=0; a subsequent REQ=10 is granted normally.
- Port 1 drops REQ the cycle after GNT -> transaction completes, ACK=10 still pulses; port 0 REQ raised mid-transaction is granted only after RESP.
